// File: rtl/peripheral_msi_bridge_wb.sv
// Registered Wishbone classic bridge: one master-side request is replayed to the
// slave, and the slave's termination (or a watchdog error) is returned one cycle later.
module peripheral_msi_bridge_wb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [AW-1:0]   wbm_adr_i,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic [DW/8-1:0] wbm_sel_i,
    input  logic            wbm_we_i,
    input  logic            wbm_cyc_i,
    input  logic            wbm_stb_i,
    output logic [DW-1:0]   wbm_dat_o,
    output logic            wbm_ack_o,
    output logic            wbm_err_o,
    output logic            wbm_rty_o,
    output logic [AW-1:0]   wbs_adr_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic [DW/8-1:0] wbs_sel_o,
    output logic            wbs_we_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i,
    input  logic            wbs_rty_i,
    output logic            busy_o,
    output logic            timeout_o
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wdog;
    logic          slave_term;
    logic          expire;

    assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // With TIMEOUT=0 the comparison is masked so the counter may wrap harmlessly.
    assign expire     = (TIMEOUT != 0) && (wdog == WD_LAST);

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state     <= IDLE;
            wdog      <= '0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_sel_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        wbs_adr_o <= wbm_adr_i;
                        wbs_dat_o <= wbm_dat_i;
                        wbs_sel_o <= wbm_sel_i;
                        wbs_we_o  <= wbm_we_i;
                        wbs_cyc_o <= 1'b1;
                        wbs_stb_o <= 1'b1;
                        wdog      <= '0;
                        busy_o    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // A vanished master takes precedence: nobody is left to take a response.
                    if (!wbm_cyc_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else if (slave_term) begin
                        wbm_dat_o <= wbs_dat_i;
                        wbm_err_o <= wbs_err_i;
                        wbm_rty_o <= !wbs_err_i && wbs_rty_i;
                        wbm_ack_o <= !wbs_err_i && !wbs_rty_i && wbs_ack_i;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state     <= RESP;
                    end else if (expire) begin
                        wbm_dat_o <= wbs_dat_i;
                        wbm_err_o <= 1'b1;
                        timeout_o <= 1'b1;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    wbs_cyc_o <= 1'b0;
                    wbs_stb_o <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
